if_pc_gen: RTL and testbench



---
 rtl/if_pc_gen_pkg.sv | 21 ++
 rtl/if_fetch_fifo.sv | 56 +++++
 rtl/if_pc_gen.sv | 168 ++++++++++++++++
 tb/tb_if_pc_gen.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pc_gen_pkg.sv
// Shared definitions for the instruction-fetch front end: reset PC default,
// NOP encoding, controller stall-bit indices and the fetch FIFO entry format.
package if_pc_gen_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] NOP_INST         = 32'h0340_0000;

  // Bit positions inside the controller stall vector.
  localparam int STALL_PC = 0;  // holds PC advance / request issue
  localparam int STALL_IF = 1;  // holds the hand-off to if_buffer_1

  // One buffered fetch result as presented to if_buffer_1.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO used both for buffered fetch results and for the
// tag queue of in-flight request PCs. Push and pop may coincide when full;
// clear empties the FIFO in one cycle. Head is valid whenever count != 0.
module if_fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on empty is ignored; a push on full is accepted only alongside a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping; clear behaves like a reset.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage.
  // NOTE: the array has no reset; validity is carried by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_pc_gen.sv
// PC generation and instruction-fetch front end (first pipeline stage).
// Issues in-order fetch requests under a credit scheme that reserves a FIFO
// slot for every live in-flight request, drops responses that belong to
// requests issued before a flush/branch redirect, and buffers results for
// if_buffer_1.
// Optional feature macro: IF_ADEF_CHECK_EN (misaligned-PC address error
// entries instead of memory requests).
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          BUF_DEPTH       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] inst_o,
  output logic        excp_adef_o
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]        pc;
  logic [CNT_W-1:0]   outstanding;   // every request in flight, stale or live
  logic [CNT_W-1:0]   discard;       // in-flight requests whose data is dropped
  logic [CNT_W-1:0]   tag_count;     // live in-flight requests
  logic [31:0]        tag_head;
  logic [FCNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  fetch_entry_t       head_e;
  fetch_entry_t       push_entry;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        credit_ok;
  logic        issue_ok;
  logic        fire;
  logic        resp_live;
  logic        adef_push;
  logic        push;
  logic        pop;

  // Flush outranks a branch redirect issued in the same cycle.
  assign redirect    = flush || branch_flag_i;
  assign redirect_pc = flush ? new_pc : branch_target_i;

  // Live requests plus buffered entries must leave room for one more entry;
  // the memory-side limit counts stale requests as well.
  assign credit_ok = (int'(tag_count) + int'(fifo_count) < BUF_DEPTH) &&
                     (int'(outstanding) < MAX_OUTSTANDING);
  assign issue_ok  = rst_n && !stall[STALL_PC] && !redirect && credit_ok;

`ifdef IF_ADEF_CHECK_EN
  logic pc_misaligned;
  logic adef_sent;

  assign pc_misaligned    = (pc[1:0] != 2'b00);
  assign imem_req_valid_o = issue_ok && !pc_misaligned;
  // The error entry waits for earlier live requests so output order is kept,
  // and is produced once per redirect while the PC holds.
  assign adef_push = issue_ok && pc_misaligned && !adef_sent && (tag_count == '0);

  // Remembers that the address-error entry for the current PC was queued.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect) adef_sent <= 1'b0;
    else if (adef_push)     adef_sent <= 1'b1;
  end
`else
  assign imem_req_valid_o = issue_ok;
  assign adef_push        = 1'b0;
`endif

  assign imem_addr_o = pc;
  assign fire        = imem_req_valid_o && imem_req_ready_i;
  assign resp_live   = imem_resp_valid_i && (discard == '0) && !redirect;
  assign push        = resp_live || adef_push;

  // Select what enters the output FIFO: a memory response or an error entry.
  // NOTE: the default is assigned first so no path leaves it unassigned (no latch).
  always_comb begin
    push_entry      = '0;
    push_entry.pc   = tag_head;
    push_entry.inst = imem_rdata_i;
    if (adef_push) begin
      push_entry.pc   = pc;
      push_entry.inst = NOP_INST;
      push_entry.adef = 1'b1;
    end
  end

  // PC and in-flight bookkeeping; a redirect turns every pending request stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      outstanding <= outstanding - CNT_W'(imem_resp_valid_i);
      discard     <= outstanding - CNT_W'(imem_resp_valid_i);
    end else begin
      if (fire) pc <= pc + 32'd4;
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(imem_resp_valid_i);
      if (imem_resp_valid_i && (discard != '0)) discard <= discard - 1'b1;
    end
  end

  // PCs of live requests, matched in order against returning data.
  if_fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (32)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (fire),
    .push_data (pc),
    .pop       (resp_live),
    .head      (tag_head),
    .count     (tag_count)
  );

  // Buffered fetch results awaiting if_buffer_1.
  if_fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign head_e       = fetch_entry_t'(fifo_head);
  assign inst_valid_o = (fifo_count != '0) && !redirect;
  assign pop          = inst_valid_o && !stall[STALL_IF];
  // Outputs read zero while nothing is buffered.
  assign inst_pc_o    = (fifo_count != '0) ? head_e.pc   : '0;
  assign inst_o       = (fifo_count != '0) ? head_e.inst : '0;

`ifdef IF_ADEF_CHECK_EN
  assign excp_adef_o = (fifo_count != '0) && head_e.adef;
  logic unused_bits;
  assign unused_bits = ^stall[6:2];
`else
  assign excp_adef_o = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{stall[6:2], head_e.adef};
`endif

endmodule

// File: tb/tb_if_pc_gen.sv
// Self-checking bench for if_pc_gen: directed scenarios followed by
// randomized controller/memory traffic, compared every cycle against a
// stream-level reference model of the fetch front end.
module tb_if_pc_gen;
  import if_pc_gen_pkg::*;

  localparam int          MAX_OUT = 2;
  localparam int          BUF     = 2;
  localparam logic [31:0] RPC     = 32'h1c00_0000;

  logic        clk;
  logic        rst_n;
  logic [6:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_o;
  logic        excp_adef_o;

  if_pc_gen #(
    .RESET_PC        (RPC),
    .MAX_OUTSTANDING (MAX_OUT),
    .BUF_DEPTH       (BUF)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .branch_flag_i     (branch_flag_i),
    .branch_target_i   (branch_target_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_addr_o       (imem_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_rdata_i      (imem_rdata_i),
    .inst_valid_o      (inst_valid_o),
    .inst_pc_o         (inst_pc_o),
    .inst_o            (inst_o),
    .excp_adef_o       (excp_adef_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t        mem_q[$];    // accepted requests not yet answered, oldest first
  fetch_entry_t fifo_m[$];   // entries the front end must present, in order
  logic [31:0]  exp_issue;   // address of the next request to be issued
  bit           adef_sent_m;
  int           cyc = 0;
  int           lat_min = 1;
  int           lat_max = 1;
  int           resp_pct = 100;

  logic [31:0]  issue_log[$];
  logic [31:0]  pop_log[$];
  logic [31:0]  pop_inst_log[$];
  logic [31:0]  pop_adef_log[$];

  int           m_live;
  bit           m_redir;
  bit           m_misal;
  bit           m_allowed;
  bit           m_rv;
  bit           m_iv;
  logic [31:0]  m_tgt;
  mreq_t        m_r;

  // Per-cycle comparison and model advance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_q.delete();
      fifo_m.delete();
      exp_issue   = RPC;
      adef_sent_m = 1'b0;
    end else begin
      m_live = 0;
      foreach (mem_q[i]) if (!mem_q[i].stale) m_live++;
      m_redir = flush || branch_flag_i;
      m_tgt   = flush ? new_pc : branch_target_i;
      m_misal = 1'b0;
`ifdef IF_ADEF_CHECK_EN
      m_misal = (exp_issue[1:0] != 2'b00);
`endif
      m_allowed = !stall[0] && !m_redir && (m_live + fifo_m.size() < BUF) &&
                  (mem_q.size() < MAX_OUT);
      m_rv = m_allowed && !m_misal;
      m_iv = (fifo_m.size() > 0) && !m_redir;

      check("req_valid", 32'(imem_req_valid_o), 32'(m_rv));
      check("inst_valid", 32'(inst_valid_o), 32'(m_iv));
      if (m_rv) check("req_addr", imem_addr_o, exp_issue);
      if (m_iv) begin
        check("inst_pc", inst_pc_o, fifo_m[0].pc);
        check("inst", inst_o, fifo_m[0].inst);
        check("adef", 32'(excp_adef_o), 32'(fifo_m[0].adef));
      end

      if (imem_req_valid_o && imem_req_ready_i) issue_log.push_back(imem_addr_o);
      if (inst_valid_o && !stall[1]) begin
        pop_log.push_back(inst_pc_o);
        pop_inst_log.push_back(inst_o);
        pop_adef_log.push_back(32'(excp_adef_o));
      end

      if (m_iv && !stall[1]) void'(fifo_m.pop_front());
      if (imem_resp_valid_i && (mem_q.size() > 0)) begin
        m_r = mem_q.pop_front();
        if (!m_r.stale && !m_redir)
          fifo_m.push_back('{pc: m_r.addr, inst: memf(m_r.addr), adef: 1'b0});
      end
      if (m_redir) begin
        fifo_m.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_issue   = m_tgt;
        adef_sent_m = 1'b0;
      end else if (m_rv && imem_req_ready_i) begin
        mem_q.push_back('{addr: exp_issue,
                          due: cyc + int'($urandom_range(lat_min, lat_max)),
                          stale: 1'b0});
        exp_issue = exp_issue + 32'd4;
      end else if (m_allowed && m_misal && !adef_sent_m && (m_live == 0)) begin
        fifo_m.push_back('{pc: exp_issue, inst: NOP_INST, adef: 1'b1});
        adef_sent_m = 1'b1;
      end
    end
  end

  // Advance one clock; the memory model answers the oldest due request.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && (mem_q.size() > 0) && (mem_q[0].due <= cyc) &&
        ($urandom_range(0, 99) < resp_pct)) begin
      imem_resp_valid_i = 1'b1;
      imem_rdata_i      = memf(mem_q[0].addr);
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_rdata_i      = $urandom;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] log_at(input logic [31:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 32'hdead_beef;
  endfunction

  int          i_idx;
  int          p_idx;
  int          n_wait;
  logic [31:0] hold_addr;

  initial begin
    rst_n             = 1'b0;
    stall             = '0;
    flush             = 1'b0;
    new_pc            = '0;
    branch_flag_i     = 1'b0;
    branch_target_i   = '0;
    imem_req_ready_i  = 1'b1;
    imem_resp_valid_i = 1'b0;
    imem_rdata_i      = '0;

    // Reset state.
    ticks(2);
    check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst_pc", inst_pc_o, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_adef", 32'(excp_adef_o), 32'd0);
    rst_n = 1'b1;

    // Sequential fetch, ready=1, 1-cycle latency.
    ticks(12);
    check("seq_issue0", log_at(issue_log, 0), 32'h1c00_0000);
    check("seq_issue1", log_at(issue_log, 1), 32'h1c00_0004);
    check("seq_issue2", log_at(issue_log, 2), 32'h1c00_0008);
    check("seq_pop0", log_at(pop_log, 0), 32'h1c00_0000);
    check("seq_pop1", log_at(pop_log, 1), 32'h1c00_0004);
    check("seq_pop2", log_at(pop_log, 2), 32'h1c00_0008);
    check("seq_inst0", log_at(pop_inst_log, 0), memf(32'h1c00_0000));

    // Stall issue and output for 5 cycles; responses still land.
    i_idx = issue_log.size();
    p_idx = pop_log.size();
    stall = 7'b000_0011;
    ticks(5);
    check("stall_no_issue", 32'(issue_log.size() - i_idx), 32'd0);
    check("stall_no_pop", 32'(pop_log.size() - p_idx), 32'd0);
    check("stall_buffered", 32'(inst_valid_o), 32'd1);
    stall = '0;
    ticks(10);
    for (int k = 0; k < pop_log.size(); k++)
      check("drain_order", pop_log[k], RPC + 32'(4 * k));

    // Two requests in flight, then flush to 0000000c.
    lat_min = 3;
    lat_max = 3;
    n_wait  = 0;
    while ((mem_q.size() < 2) && (n_wait < 20)) begin
      tick();
      n_wait++;
    end
    check("flush_setup_inflight", 32'(mem_q.size()), 32'd2);
    i_idx  = issue_log.size();
    p_idx  = pop_log.size();
    flush  = 1'b1;
    new_pc = 32'h0000_000c;
    tick();
    flush   = 1'b0;
    lat_min = 1;
    lat_max = 1;
    ticks(12);
    check("flush_issue", log_at(issue_log, i_idx), 32'h0000_000c);
    check("flush_pop", log_at(pop_log, p_idx), 32'h0000_000c);

    // Flush and branch together: flush wins.
    i_idx           = issue_log.size();
    p_idx           = pop_log.size();
    flush           = 1'b1;
    new_pc          = 32'h0000_000c;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h1c00_0100;
    tick();
    flush         = 1'b0;
    branch_flag_i = 1'b0;
    ticks(10);
    check("prio_issue", log_at(issue_log, i_idx), 32'h0000_000c);
    check("prio_pop", log_at(pop_log, p_idx), 32'h0000_000c);

    // Memory not ready for 3 cycles: address held, PC not advancing.
    hold_addr        = exp_issue;
    imem_req_ready_i = 1'b0;
    ticks(3);
    check("notready_addr", imem_addr_o, hold_addr);
    check("notready_valid", 32'(imem_req_valid_o), 32'd1);
    imem_req_ready_i = 1'b1;
    tick();
    check("ready_advance", exp_issue, hold_addr + 32'd4);
    ticks(4);

    // Randomized traffic with one reset in the middle.
    lat_min  = 1;
    lat_max  = 3;
    resp_pct = 70;
    for (int t = 0; t < 3000; t++) begin
      tick();
      stall            = {5'($urandom), ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 25)};
      imem_req_ready_i = ($urandom_range(0, 99) < 70);
      flush            = ($urandom_range(0, 99) < 2);
      new_pc           = $urandom & 32'hffff_fffc;
      branch_flag_i    = ($urandom_range(0, 99) < 3);
      branch_target_i  = $urandom & 32'hffff_fffc;
      rst_n            = !((t == 1500) || (t == 1501));
    end
    tick();
    stall            = '0;
    flush            = 1'b0;
    branch_flag_i    = 1'b0;
    imem_req_ready_i = 1'b1;
    lat_min          = 1;
    lat_max          = 1;
    resp_pct         = 100;
    ticks(10);

`ifdef IF_ADEF_CHECK_EN
    // Branch to a misaligned target: an error entry instead of a request.
    i_idx           = issue_log.size();
    p_idx           = pop_log.size();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h1c00_0102;
    tick();
    branch_flag_i = 1'b0;
    ticks(10);
    check("adef_no_issue", 32'(issue_log.size() - i_idx), 32'd0);
    check("adef_pc", log_at(pop_log, p_idx), 32'h1c00_0102);
    check("adef_inst", log_at(pop_inst_log, p_idx), 32'h0340_0000);
    check("adef_flag", log_at(pop_adef_log, p_idx), 32'd1);
    check("adef_single", 32'(pop_log.size() - p_idx), 32'd1);
    i_idx  = issue_log.size();
    flush  = 1'b1;
    new_pc = 32'h0000_000c;
    tick();
    flush = 1'b0;
    ticks(10);
    check("adef_resume", log_at(issue_log, i_idx), 32'h0000_000c);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
